vc32_write_buffer: RTL and testbench
====================================

Name: vc32_write_buffer

Overview:
- Posted-write buffer with read bypass, between the vc32 cpu memory port and the off-chip pin bus sequencer.
- Captures CPU writes into a small in-order FIFO and returns wdone early.
- Drains the FIFO to the sequencer one write at a time. Reads are sent to the sequencer ahead of queued writes unless they hit a queued address.
- Both sides use the same request/done protocol: the requester holds its request until a one-cycle done pulse, then drops it the next cycle.

Parameters:
- PA, 18, physical address width in bits; addresses are 16-bit word addresses [PA-1:1].
- DEPTH, 2, write FIFO entries; legal values are 1, 2 and 4.

Ports:
- clk  in  1  clock
- r_reset  in  1  synchronous, active-high reset
- c_raddr  in  PA-1  CPU read word address [PA-1:1]
- c_rreq  in  2  CPU read byte request; [0] = low byte, [1] = high byte
- c_rdata  out  16  read data to the CPU
- c_rdone  out  1  read-complete pulse to the CPU
- c_waddr  in  PA-1  CPU write word address
- c_wmask  in  2  CPU write byte mask; non-zero = request
- c_wdata  in  16  CPU write data
- c_wdone  out  1  write-accepted pulse to the CPU
- m_raddr  out  PA-1  sequencer read address
- m_rreq  out  2  sequencer read request
- m_rdata  in  16  sequencer read data
- m_rdone  in  1  sequencer read-done pulse
- m_waddr  out  PA-1  sequencer write address
- m_wmask  out  2  sequencer write mask
- m_wdata  out  16  sequencer write data
- m_wdone  in  1  sequencer write-done pulse
- wb_empty  out  1  FIFO holds no valid entry
- wb_full  out  1  FIFO holds DEPTH entries

Behaviour:
- Reset values:
  - all FIFO valid bits cleared, rd/wr pointers 0, count 0, FSM in IDLE;
  - c_rdone=0, c_wdone=0, m_rreq=0, m_wmask=0;
  - c_rdata=0, m_raddr=0, m_waddr=0, m_wdata=0;
  - wb_empty=1, wb_full=0.
- Reset mid-transaction abandons the transaction. The sequencer shares r_reset, so both sides restart clean.
- FIFO entry = {addr[PA-1:1], mask[1:0], data[15:0]}. Pointers wrap modulo DEPTH. count ranges 0..DEPTH; wb_full/wb_empty are registered from count.
- Write accept: capture when c_wmask!=0, !wb_full and c_wdone==0.
  - c_wdone pulses exactly one cycle, in the cycle after capture.
  - The request is still held while c_wdone is high and must not be captured a second time.
  - When wb_full, c_wdone is withheld until a slot frees. The slot becomes usable in the cycle after the m_wdone that retires it.
- Same-cycle capture and retire: count stays unchanged and both pointers advance.
- Memory FSM states:
  - IDLE: evaluate issue priority (below).
  - RD: m_rreq/m_raddr registered from the CPU request. On m_rdone: c_rdata<=m_rdata, c_rdone=1 next cycle, m_rreq=0 next cycle, go to RDONE.
  - RDONE: c_rdone high for this one cycle, then back to IDLE. The CPU's held rreq is ignored in this cycle.
  - WR: m_waddr/m_wmask/m_wdata taken from the FIFO head. On m_wdone: m_wmask=0 next cycle, pop head, go to IDLE.
- Issue priority in IDLE, highest first:
  1. wb_full and !wb_empty: drain (WR). This rule prevents drain starvation.
  2. Valid c_rreq with no hazard: read (RD).
  3. !wb_empty: drain (WR).
- Hazard: any valid entry whose addr == c_raddr, compared on the full word address regardless of mask.
  - While a hazard exists the read is not issued. The FIFO drains until no match remains, then the read issues.
  - No data forwarding.
- Write ordering: writes reach the sequencer in CPU acceptance order. A read never passes a write to the same word.
- m_rreq and m_wmask are never both non-zero, and are never asserted in the cycle after a done pulse. This gives the sequencer its idle gap.
- m_rreq passes c_rreq unchanged (1, 2 or 3). c_rdata bytes not requested hold m_rdata as delivered.
- Latency:
  - write accept: 1 cycle (capture, then wdone);
  - read: c_rdone arrives 1 cycle after m_rdone; m_rreq is asserted the cycle after the CPU request is seen in IDLE.

Test Plan:
- Reset, then a single write addr=0x01234 mask=3 data=0xBEEF. Expect c_wdone high in cycle 2 only, wb_empty=0. Then m_waddr=0x01234, m_wmask=3, m_wdata=0xBEEF until m_wdone; wb_empty=1 the cycle after m_wdone.
- Three back-to-back writes with DEPTH=2 and the sequencer stalled. Expect the first two acked and wb_full=1; the third gets no c_wdone until the first m_wdone, then is acked. Drain order on m_waddr is A, B, C.
- Queued write to 0x00100 with the sequencer slow, then a read of 0x00200 rreq=3. Expect m_rreq=3 for 0x00200 issued before the queued write. m_rdata=0x5A5A gives c_rdata=0x5A5A and a one-cycle c_rdone.
- Queued write to 0x00100, then a read of 0x00100. Expect the write drained first (m_wdone), then m_rreq issued; m_rreq and m_wmask are never high together.
- Buffer full and the CPU issuing continuous non-hazard reads. Expect a drain issued on the first IDLE cycle while wb_full=1.
- Assert r_reset while in RD with 2 entries queued. Expect all outputs at reset values the next cycle, wb_empty=1, and no stale drain after reset.

Source files
------------

// File: rtl/vc32_write_buffer.sv
// Posted-write buffer between the vc32 CPU memory port and the pin bus sequencer.
// CPU writes are acked from a small FIFO; reads bypass queued writes unless they hit a queued word.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | choose next sequencer op: forced drain, read, or drain
// RD     | read outstanding on m_rreq, waiting for m_rdone
// RDONE  | c_rdone pulse; held CPU rreq is ignored here
// WR     | FIFO head presented on m_w*, waiting for m_wdone
module vc32_write_buffer #(
    parameter int PA    = 18,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          r_reset,
    input  logic [PA-1:1] c_raddr,
    input  logic [1:0]    c_rreq,
    output logic [15:0]   c_rdata,
    output logic          c_rdone,
    input  logic [PA-1:1] c_waddr,
    input  logic [1:0]    c_wmask,
    input  logic [15:0]   c_wdata,
    output logic          c_wdone,
    output logic [PA-1:1] m_raddr,
    output logic [1:0]    m_rreq,
    input  logic [15:0]   m_rdata,
    input  logic          m_rdone,
    output logic [PA-1:1] m_waddr,
    output logic [1:0]    m_wmask,
    output logic [15:0]   m_wdata,
    input  logic          m_wdone,
    output logic          wb_empty,
    output logic          wb_full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD    = 2'd1,
        S_RDONE = 2'd2,
        S_WR    = 2'd3
    } state_t;

    state_t state, state_next;

    logic [PA-1:1]    fifo_addr [DEPTH];
    logic [1:0]       fifo_mask [DEPTH];
    logic [15:0]      fifo_data [DEPTH];
    logic [DEPTH-1:0] fifo_valid;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count, count_next;

    logic capture, retire, hazard, rd_ok;

    logic [15:0]   c_rdata_d;
    logic          c_rdone_d;
    logic [PA-1:1] m_raddr_d;
    logic [1:0]    m_rreq_d;
    logic [PA-1:1] m_waddr_d;
    logic [1:0]    m_wmask_d;
    logic [15:0]   m_wdata_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_C)
            return '0;
        else
            return p + PW'(1);
    endfunction

    // c_wdone gating keeps a request that is still held during its ack from being taken twice
    assign capture = (c_wmask != 2'b00) && !wb_full && !c_wdone;
    assign retire  = (state == S_WR) && m_wdone;

    always_comb begin
        count_next = count;
        case ({capture, retire})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_reset) begin
            fifo_valid <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            wb_empty   <= 1'b1;
            wb_full    <= 1'b0;
            c_wdone    <= 1'b0;
        end else begin
            c_wdone <= capture;
            if (retire) begin
                fifo_valid[rd_ptr] <= 1'b0;
                rd_ptr             <= ptr_inc(rd_ptr);
            end
            if (capture) begin
                fifo_valid[wr_ptr] <= 1'b1;
                wr_ptr             <= ptr_inc(wr_ptr);
            end
            count    <= count_next;
            wb_empty <= (count_next == '0);
            wb_full  <= (count_next == DEPTH_C);
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            fifo_addr[wr_ptr] <= c_waddr;
            fifo_mask[wr_ptr] <= c_wmask;
            fifo_data[wr_ptr] <= c_wdata;
        end
    end

    // Full word-address match regardless of byte mask; no forwarding, so a hit just waits for drain
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i] && (fifo_addr[i] == c_raddr))
                hazard = 1'b1;
        end
    end

    assign rd_ok = (c_rreq != 2'b00) && !hazard;

    always_ff @(posedge clk) begin
        if (r_reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (wb_full && !wb_empty)
                    state_next = S_WR;
                else if (rd_ok)
                    state_next = S_RD;
                else if (!wb_empty)
                    state_next = S_WR;
            end
            S_RD:    if (m_rdone) state_next = S_RDONE;
            S_RDONE: state_next = S_IDLE;
            S_WR:    if (m_wdone) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Next values for the registered bus outputs; issuing only from IDLE gives the post-done gap
    always_comb begin
        c_rdata_d = c_rdata;
        c_rdone_d = 1'b0;
        m_raddr_d = m_raddr;
        m_rreq_d  = m_rreq;
        m_waddr_d = m_waddr;
        m_wmask_d = m_wmask;
        m_wdata_d = m_wdata;
        case (state)
            S_IDLE: begin
                if (state_next == S_RD) begin
                    m_rreq_d  = c_rreq;
                    m_raddr_d = c_raddr;
                end else if (state_next == S_WR) begin
                    m_waddr_d = fifo_addr[rd_ptr];
                    m_wmask_d = fifo_mask[rd_ptr];
                    m_wdata_d = fifo_data[rd_ptr];
                end
            end
            S_RD: begin
                if (m_rdone) begin
                    c_rdata_d = m_rdata;
                    c_rdone_d = 1'b1;
                    m_rreq_d  = 2'b00;
                end
            end
            S_WR: begin
                if (m_wdone)
                    m_wmask_d = 2'b00;
            end
            default: begin
                c_rdone_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_reset) begin
            c_rdata <= '0;
            c_rdone <= 1'b0;
            m_raddr <= '0;
            m_rreq  <= 2'b00;
            m_waddr <= '0;
            m_wmask <= 2'b00;
            m_wdata <= '0;
        end else begin
            c_rdata <= c_rdata_d;
            c_rdone <= c_rdone_d;
            m_raddr <= m_raddr_d;
            m_rreq  <= m_rreq_d;
            m_waddr <= m_waddr_d;
            m_wmask <= m_wmask_d;
            m_wdata <= m_wdata_d;
        end
    end

endmodule

// File: tb/tb_vc32_write_buffer.sv
// Directed bench for vc32_write_buffer: behavioural sequencer responder plus write/read scoreboards.
module tb_vc32_write_buffer;
    localparam int PA    = 18;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          r_reset;
    logic [PA-1:1] c_raddr, c_waddr, m_raddr, m_waddr;
    logic [1:0]    c_rreq, c_wmask, m_rreq, m_wmask;
    logic [15:0]   c_rdata, c_wdata, m_rdata, m_wdata;
    logic          c_rdone, c_wdone, m_rdone, m_wdone, wb_empty, wb_full;

    always #5 clk = ~clk;

    vc32_write_buffer #(.PA(PA), .DEPTH(DEPTH)) dut (
        .clk(clk), .r_reset(r_reset),
        .c_raddr(c_raddr), .c_rreq(c_rreq), .c_rdata(c_rdata), .c_rdone(c_rdone),
        .c_waddr(c_waddr), .c_wmask(c_wmask), .c_wdata(c_wdata), .c_wdone(c_wdone),
        .m_raddr(m_raddr), .m_rreq(m_rreq), .m_rdata(m_rdata), .m_rdone(m_rdone),
        .m_waddr(m_waddr), .m_wmask(m_wmask), .m_wdata(m_wdata), .m_wdone(m_wdone),
        .wb_empty(wb_empty), .wb_full(wb_full)
    );

    typedef struct packed {
        logic [PA-1:1] addr;
        logic [1:0]    mask;
        logic [15:0]   data;
    } wr_t;

    wr_t         wq[$];
    logic [15:0] rq[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic wstall = 1'b0, rstall = 1'b0;
    int wlat = 2, rlat = 2, wcnt = 0, rcnt = 0;
    logic [15:0] rd_val = 16'h0000;
    int mwdone_cyc = 0, wdone_cyc = 0, rreq_rise_cyc = 0;
    logic wdone_seen = 1'b0, rreq_seen = 1'b0, wmask_seen = 1'b0, rreq_prev = 1'b0;

    task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: invariants, sequencer responder, then CPU-side monitors
    task automatic tick();
        wr_t  w;
        logic pd;
        @(posedge clk);
        #1;
        cyc++;
        pd = m_wdone | m_rdone;
        check("mutex_rreq_wmask", (m_rreq != 2'b00) && (m_wmask != 2'b00), 1'b0);
        if (pd)
            check("idle_gap_after_done", (m_rreq != 2'b00) || (m_wmask != 2'b00), 1'b0);
        m_wdone = 1'b0;
        m_rdone = 1'b0;
        if (r_reset) begin
            wcnt = 0;
            rcnt = 0;
        end else begin
            if (m_wmask != 2'b00 && !pd && !wstall) begin
                wcnt++;
                if (wcnt >= wlat) begin
                    m_wdone    = 1'b1;
                    wcnt       = 0;
                    mwdone_cyc = cyc;
                    check("drain_expected", wq.size() != 0, 1'b1);
                    if (wq.size() != 0) begin
                        w = wq.pop_front();
                        check("drain_addr", m_waddr, w.addr);
                        check("drain_mask", m_wmask, w.mask);
                        check("drain_data", m_wdata, w.data);
                    end
                end
            end
            if (m_rreq != 2'b00 && !pd && !rstall) begin
                rcnt++;
                if (rcnt >= rlat) begin
                    m_rdone = 1'b1;
                    m_rdata = rd_val;
                    rcnt    = 0;
                end
            end
        end
        if (c_wdone) begin
            wdone_seen = 1'b1;
            wdone_cyc  = cyc;
        end
        if (c_rdone) begin
            check("read_expected", rq.size() != 0, 1'b1);
            if (rq.size() != 0)
                check("c_rdata", c_rdata, rq.pop_front());
        end
        if (m_wmask != 2'b00) wmask_seen = 1'b1;
        if (m_rreq != 2'b00) rreq_seen = 1'b1;
        if (m_rreq != 2'b00 && !rreq_prev) rreq_rise_cyc = cyc;
        rreq_prev = (m_rreq != 2'b00);
    endtask

    task automatic cpu_write(input logic [PA-1:1] a, input logic [1:0] m, input logic [15:0] d);
        c_waddr = a;
        c_wmask = m;
        c_wdata = d;
        wq.push_back('{addr: a, mask: m, data: d});
    endtask

    task automatic wait_wdone(input string tag);
        for (int i = 0; i < 40 && !c_wdone; i++) tick();
        check(tag, c_wdone, 1'b1);
    endtask

    task automatic wait_rdone(input string tag);
        for (int i = 0; i < 60 && !c_rdone; i++) tick();
        check(tag, c_rdone, 1'b1);
    endtask

    // Hold the request through its ack cycle, then drop it
    task automatic write_acked(input logic [PA-1:1] a, input logic [1:0] m, input logic [15:0] d,
                               input string tag);
        cpu_write(a, m, d);
        wait_wdone({tag, "_ack"});
        tick();
        check({tag, "_ack_once"}, c_wdone, 1'b0);
        c_wmask = 2'b00;
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 100 && !(wb_empty === 1'b1 && m_wmask == 2'b00 && m_rreq == 2'b00); i++)
            tick();
        check(tag, wb_empty, 1'b1);
        check({tag, "_wq"}, wq.size(), 0);
        check({tag, "_rq"}, rq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        r_reset = 1'b1;
        c_raddr = '0; c_rreq = 2'b00; c_waddr = '0; c_wmask = 2'b00; c_wdata = '0;
        m_rdata = '0; m_rdone = 1'b0; m_wdone = 1'b0;

        // reset values
        tick();
        tick();
        check("rst_wb_empty", wb_empty, 1'b1);
        check("rst_wb_full", wb_full, 1'b0);
        check("rst_c_wdone", c_wdone, 1'b0);
        check("rst_c_rdone", c_rdone, 1'b0);
        check("rst_m_rreq", m_rreq, 2'b00);
        check("rst_m_wmask", m_wmask, 2'b00);
        r_reset = 1'b0;
        tick();

        // single write, ack latency and drain
        wlat = 3;
        cpu_write(17'h01234, 2'b11, 16'hBEEF);
        tick();
        check("t1_wdone", c_wdone, 1'b1);
        check("t1_not_empty", wb_empty, 1'b0);
        tick();
        check("t1_wdone_once", c_wdone, 1'b0);
        check("t1_single_capture", wb_full, 1'b0);
        c_wmask = 2'b00;
        check("t1_waddr", m_waddr, 17'h01234);
        check("t1_wmask", m_wmask, 2'b11);
        check("t1_wdata", m_wdata, 16'hBEEF);
        for (int i = 0; i < 20 && !m_wdone; i++) tick();
        check("t1_mwdone", m_wdone, 1'b1);
        tick();
        check("t1_empty_after", wb_empty, 1'b1);
        check("t1_wmask_low", m_wmask, 2'b00);

        // three writes into a stalled two-entry buffer
        wlat = 2;
        wstall = 1'b1;
        write_acked(17'h02000, 2'b01, 16'h1111, "t2_a");
        write_acked(17'h02001, 2'b10, 16'h2222, "t2_b");
        check("t2_full", wb_full, 1'b1);
        cpu_write(17'h02002, 2'b11, 16'h3333);
        wdone_seen = 1'b0;
        repeat (6) tick();
        check("t2_c_withheld", wdone_seen, 1'b0);
        wstall = 1'b0;
        wait_wdone("t2_c_ack");
        check("t2_c_ack_timing", wdone_cyc - mwdone_cyc, 2);
        tick();
        c_wmask = 2'b00;
        wait_empty("t2_drained");

        // read bypasses a queued non-matching write
        wstall = 1'b1;
        rd_val = 16'h5A5A;
        cpu_write(17'h00100, 2'b11, 16'hAAAA);
        wait_wdone("t3_w_ack");
        c_raddr = 17'h00200;
        c_rreq  = 2'b11;
        rq.push_back(16'h5A5A);
        tick();
        c_wmask = 2'b00;
        check("t3_rreq", m_rreq, 2'b11);
        check("t3_raddr", m_raddr, 17'h00200);
        check("t3_wmask_held_off", m_wmask, 2'b00);
        wait_rdone("t3_rdone");
        tick();
        c_rreq = 2'b00;
        check("t3_rdone_pulse", c_rdone, 1'b0);
        wstall = 1'b0;
        wait_empty("t3_drained");

        // read hitting a queued write waits for that write to drain
        wstall = 1'b1;
        rd_val = 16'h1234;
        cpu_write(17'h00100, 2'b01, 16'h00CC);
        wait_wdone("t4_w_ack");
        c_raddr = 17'h00100;
        c_rreq  = 2'b10;
        rq.push_back(16'h1234);
        rreq_seen = 1'b0;
        tick();
        c_wmask = 2'b00;
        check("t4_write_first", m_wmask, 2'b01);
        repeat (5) tick();
        check("t4_read_blocked", rreq_seen, 1'b0);
        wstall = 1'b0;
        wait_rdone("t4_rdone");
        check("t4_read_after_drain", rreq_rise_cyc - mwdone_cyc, 2);
        tick();
        c_rreq = 2'b00;
        wait_empty("t4_drained");

        // full buffer drains ahead of a continuously held read
        wstall = 1'b1;
        rd_val = 16'hC0DE;
        write_acked(17'h00400, 2'b11, 16'h4444, "t5_a");
        write_acked(17'h00401, 2'b11, 16'h5555, "t5_b");
        check("t5_full", wb_full, 1'b1);
        cpu_write(17'h00402, 2'b11, 16'h6666);
        c_raddr = 17'h00300;
        c_rreq  = 2'b01;
        rq.push_back(16'hC0DE);
        wstall = 1'b0;
        wait_wdone("t5_c_ack");
        tick();
        c_wmask = 2'b00;
        wait_rdone("t5_rdone1");
        rq.push_back(16'hC0DE);
        tick();
        check("t5_full_in_idle", wb_full, 1'b1);
        tick();
        check("t5_forced_drain", m_wmask, 2'b11);
        check("t5_forced_addr", m_waddr, 17'h00401);
        check("t5_read_deferred", m_rreq, 2'b00);
        wait_rdone("t5_rdone2");
        tick();
        c_rreq = 2'b00;
        wait_empty("t5_drained");

        // reset while a read is outstanding with two writes queued
        rstall = 1'b1;
        wstall = 1'b1;
        rd_val = 16'h7777;
        cpu_write(17'h00500, 2'b11, 16'h7070);
        wait_wdone("t6_a_ack");
        c_raddr = 17'h00600;
        c_rreq  = 2'b11;
        tick();
        c_wmask = 2'b00;
        check("t6_in_rd", m_rreq, 2'b11);
        cpu_write(17'h00501, 2'b11, 16'h7171);
        wait_wdone("t6_b_ack");
        check("t6_full", wb_full, 1'b1);
        r_reset = 1'b1;
        c_wmask = 2'b00;
        c_rreq  = 2'b00;
        tick();
        check("t6_rst_empty", wb_empty, 1'b1);
        check("t6_rst_full", wb_full, 1'b0);
        check("t6_rst_m_rreq", m_rreq, 2'b00);
        check("t6_rst_m_wmask", m_wmask, 2'b00);
        check("t6_rst_c_rdone", c_rdone, 1'b0);
        check("t6_rst_c_wdone", c_wdone, 1'b0);
        check("t6_rst_c_rdata", c_rdata, 16'h0000);
        check("t6_rst_m_raddr", m_raddr, 17'h00000);
        check("t6_rst_m_waddr", m_waddr, 17'h00000);
        check("t6_rst_m_wdata", m_wdata, 16'h0000);
        r_reset = 1'b0;
        wq.delete();
        rq.delete();
        rstall = 1'b0;
        wstall = 1'b0;
        wmask_seen = 1'b0;
        rreq_seen  = 1'b0;
        repeat (10) tick();
        check("t6_no_stale_drain", wmask_seen, 1'b0);
        check("t6_no_stale_read", rreq_seen, 1'b0);
        check("t6_still_empty", wb_empty, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
